paralelo_serial_tx: RTL and testbench

//  Transmit-side neighbour of serial_paralelo: parallel-to-serial converter.

---
 rtl/paralelo_serial_tx.sv | 109 ++++++++++
 tb/tb_paralelo_serial_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: bytes in over valid/ready, shifted out MSB first.
// Starts with a burst of idle (comma) frames so the receiver can align, then fills gaps with idles.
module paralelo_serial_tx #(
   parameter logic [7:0]  IDLE_SYM    = 8'hBC,
   parameter int unsigned SYNC_FRAMES = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       frame_start,
   output logic       active
);

   typedef enum logic {
      ST_SYNC   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam logic [3:0] SYNC_LAST = 4'(SYNC_FRAMES);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_shreg;
   logic [7:0] w_shreg_nxt;
   logic [7:0] r_hold;
   logic [7:0] w_hold_nxt;
   logic       r_hold_full;
   logic       w_hold_full_nxt;
   logic [3:0] r_sync_cnt;
   logic [3:0] w_sync_cnt_nxt;
   logic       w_boundary;
   logic       w_accept;

   assign w_boundary  = (r_bit_cnt == 3'd7);
   assign active      = (r_state == ST_ACTIVE);
   assign ready_out   = active & ~r_hold_full;
   assign w_accept    = valid_in & ready_out;
   assign data_out    = r_shreg[7];
   assign frame_start = (r_bit_cnt == 3'd0);

   // Next-state: frame loading at the boundary, handshake capture elsewhere
   always_comb begin
      w_state_nxt     = r_state;
      w_shreg_nxt     = {r_shreg[6:0], 1'b0};
      w_hold_nxt      = r_hold;
      w_hold_full_nxt = r_hold_full;
      w_sync_cnt_nxt  = r_sync_cnt;
      if (w_boundary) begin
         case (r_state)
            ST_SYNC: begin
               w_shreg_nxt    = IDLE_SYM;
               w_sync_cnt_nxt = r_sync_cnt + 4'd1;
               if ((r_sync_cnt + 4'd1) == SYNC_LAST) begin
                  w_state_nxt = ST_ACTIVE;
               end else begin
                  w_state_nxt = ST_SYNC;
               end
            end
            ST_ACTIVE: begin
               // A held byte always wins; otherwise a byte offered right now bypasses the hold
               if (r_hold_full) begin
                  w_shreg_nxt     = r_hold;
                  w_hold_full_nxt = 1'b0;
               end else if (w_accept) begin
                  w_shreg_nxt = data_in;
               end else begin
                  w_shreg_nxt = IDLE_SYM;
               end
            end
            default: begin
               w_state_nxt = ST_SYNC;
               w_shreg_nxt = IDLE_SYM;
            end
         endcase
      end else begin
         if (w_accept) begin
            w_hold_nxt      = data_in;
            w_hold_full_nxt = 1'b1;
         end else begin
            w_hold_nxt      = r_hold;
            w_hold_full_nxt = r_hold_full;
         end
      end
   end

   // State register; reset drops any partial frame and held byte
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         r_state     <= ST_SYNC;
         r_bit_cnt   <= 3'd7;
         r_shreg     <= 8'h00;
         r_hold      <= 8'h00;
         r_hold_full <= 1'b0;
         r_sync_cnt  <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_cnt   <= r_bit_cnt + 3'd1;
         r_shreg     <= w_shreg_nxt;
         r_hold      <= w_hold_nxt;
         r_hold_full <= w_hold_full_nxt;
         r_sync_cnt  <= w_sync_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx: vector table, directed corner cases,
// and random traffic against a frame-level reference model.
module tb_paralelo_serial_tx;

   localparam logic [7:0] IDLE = 8'hBC;
   localparam int         S    = 4;

   logic       clk_32f = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic       data_out;
   logic       frame_start;
   logic       active;

   paralelo_serial_tx #(.IDLE_SYM(8'hBC), .SYNC_FRAMES(4)) dut (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .data_out   (data_out),
      .frame_start(frame_start),
      .active     (active)
   );

   always #5 clk_32f = ~clk_32f;

   int checks = 0;
   int errors = 0;

   // Reference model: edges since release, frames started, byte on the line, one pending byte
   int         m_edges;
   int         m_frames;
   logic [7:0] m_frame;
   logic [7:0] m_pend;
   bit         m_pend_v;

   logic [7:0] rx_sh;
   logic [7:0] rx_q[$];

   typedef struct {
      bit         valid;
      logic [7:0] data;
      bit         e_ready;
      bit         e_dout;
      bit         e_fs;
      bit         e_act;
   } vec_t;
   vec_t vt[56];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return (m_frames >= S) && !m_pend_v;
   endfunction

   task automatic model_clear();
      m_edges  = 0;
      m_frames = 0;
      m_frame  = 8'h00;
      m_pend   = 8'h00;
      m_pend_v = 1'b0;
      rx_sh    = 8'h00;
      rx_q.delete();
   endtask

   // One clock: called at a falling edge, returns at the next falling edge
   task automatic cycle(input bit v, input logic [7:0] d);
      bit         acc;
      int         b;
      logic [7:0] f;
      check("ready_out", ready_out, m_ready());
      acc = v && m_ready();
      if (m_edges % 8 == 0) begin
         if (m_frames < S) m_frame = IDLE;
         else if (m_pend_v) begin
            m_frame  = m_pend;
            m_pend_v = 1'b0;
         end else if (acc) m_frame = d;
         else m_frame = IDLE;
         m_frames++;
      end else if (acc) begin
         m_pend   = d;
         m_pend_v = 1'b1;
      end
      m_edges++;
      valid_in = v;
      data_in  = d;
      @(posedge clk_32f);
      @(negedge clk_32f);
      b = (m_edges - 1) % 8;
      f = m_frame;
      check("data_out", data_out, f[7-b]);
      check("frame_start", frame_start, b == 0);
      check("active", active, m_frames >= S);
      rx_sh = {rx_sh[6:0], data_out};
      if (b == 7) rx_q.push_back(rx_sh);
   endtask

   task automatic do_reset();
      valid_in = 1'b0;
      data_in  = 8'h00;
      reset    = 1'b1;
      @(posedge clk_32f);
      @(negedge clk_32f);
      check("rst_data_out", data_out, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_ready_out", ready_out, 0);
      check("rst_active", active, 0);
      reset = 1'b0;
      model_clear();
   endtask

   task automatic idle_to_boundary();
      for (int i = 0; i < 8; i++) begin
         if (m_edges % 8 != 0) cycle(1'b0, 8'h00);
      end
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] got;
      logic [7:0] lst[3];
      logic [7:0] nonidle[$];
      int         idx;
      int         p;
      bit         v;
      logic [7:0] d;

      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = 8'h00;
      model_clear();
      @(negedge clk_32f);

      // Table: 4 sync frames, push A5 while bit_cnt==3, then an idle frame
      for (int k = 0; k < 56; k++) begin
         pat = ((k / 8) == 5) ? 8'hA5 : IDLE;
         vt[k].valid   = (k == 36);
         vt[k].data    = (k == 36) ? 8'hA5 : 8'h00;
         vt[k].e_dout  = pat[7 - (k % 8)];
         vt[k].e_fs    = ((k % 8) == 0);
         vt[k].e_act   = ((k / 8) >= 3);
         vt[k].e_ready = ((k / 8) >= 3) && !(k >= 36 && k <= 39);
      end
      do_reset();
      for (int k = 0; k < 56; k++) begin
         cycle(vt[k].valid, vt[k].data);
         check("tbl_dout", data_out, vt[k].e_dout);
         check("tbl_fs", frame_start, vt[k].e_fs);
         check("tbl_active", active, vt[k].e_act);
         check("tbl_ready", ready_out, vt[k].e_ready);
      end
      got = (rx_q.size() > 5) ? rx_q[5] : 8'h00;
      check("tbl_frame5", got, 8'hA5);
      got = (rx_q.size() > 6) ? rx_q[6] : 8'h00;
      check("tbl_frame6_idle", got, IDLE);

      // Back-to-back: valid held high with 01, 02, 03
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
      rx_q.delete();
      lst[0] = 8'h01; lst[1] = 8'h02; lst[2] = 8'h03;
      idx = 0;
      for (int n = 0; n < 40; n++) begin
         v = (idx < 3);
         d = v ? lst[idx] : 8'h00;
         if (v && m_ready()) begin
            cycle(v, d);
            idx++;
         end else begin
            cycle(v, d);
         end
      end
      p = -1;
      for (int i = 0; i < rx_q.size(); i++) if (p < 0 && rx_q[i] == 8'h01) p = i;
      check("b2b_found", p >= 0, 1);
      got = (p >= 0 && p + 1 < rx_q.size()) ? rx_q[p+1] : 8'h00;
      check("b2b_second", got, 8'h02);
      got = (p >= 0 && p + 2 < rx_q.size()) ? rx_q[p+2] : 8'h00;
      check("b2b_third", got, 8'h03);

      // Bypass: valid only on a boundary cycle with hold empty
      idle_to_boundary();
      rx_q.delete();
      cycle(1'b1, 8'h3C);
      check("bypass_hold_empty", ready_out, 1);
      for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00);
      got = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      check("bypass_frame", got, 8'h3C);

      // Reset in the middle of an FF frame
      idle_to_boundary();
      cycle(1'b1, 8'hFF);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
      check("pre_rst_bit", data_out, 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_dout", data_out, 0);
      check("async_rst_active", active, 0);
      check("async_rst_ready", ready_out, 0);
      @(negedge clk_32f);
      reset = 1'b0;
      model_clear();
      for (int i = 0; i < 40; i++) cycle(1'b1, 8'h55);
      for (int i = 0; i < 4; i++) begin
         got = (rx_q.size() > i) ? rx_q[i] : 8'h00;
         check("post_rst_idle", got, IDLE);
      end
      got = (rx_q.size() > 4) ? rx_q[4] : 8'h00;
      check("post_rst_data", got, 8'h55);

      // Loopback-style receive of 11, 22 after a fresh reset
      @(negedge clk_32f);
      do_reset();
      lst[0] = 8'h11; lst[1] = 8'h22;
      idx = 0;
      for (int n = 0; n < 64; n++) begin
         v = (idx < 2);
         d = v ? lst[idx] : 8'h00;
         if (v && m_ready()) begin
            cycle(v, d);
            idx++;
         end else begin
            cycle(v, d);
         end
      end
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] != IDLE) nonidle.push_back(rx_q[i]);
      check("loop_count", nonidle.size(), 2);
      got = (nonidle.size() > 0) ? nonidle[0] : 8'h00;
      check("loop_first", got, 8'h11);
      got = (nonidle.size() > 1) ? nonidle[1] : 8'h00;
      check("loop_second", got, 8'h22);
      got = (rx_q.size() > 3) ? rx_q[3] : 8'h00;
      check("loop_sync_idle", got, IDLE);

      // Random traffic, including data bytes equal to the idle symbol
      for (int n = 0; n < 1500; n++) begin
         v = ($urandom_range(0, 2) != 0);
         d = ($urandom_range(0, 7) == 0) ? IDLE : 8'($urandom);
         cycle(v, d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
